ws2812_bit_encoder: RTL and testbench

WS2812_BIT_ENCODER -- requirements
Module: ws2812_bit_encoder

---
 rtl/ws2812_bit_encoder_if.sv | 34 +++
 rtl/ws2812_bit_encoder.sv | 139 +++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_bit_encoder_if.sv
// Pixel-level handshake between the WS2812 frame controller and the bit encoder:
// colour capture strobe, transmit window, and the serial line / status returned.
interface ws2812_bit_encoder_if;
  logic       load_sreg;
  logic       transmit_pixel;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       data_out;
  logic       pixel_done;
  logic       protocol_err;

  modport master (
    output load_sreg,
    output transmit_pixel,
    output red,
    output green,
    output blue,
    input  data_out,
    input  pixel_done,
    input  protocol_err
  );

  modport slave (
    input  load_sreg,
    input  transmit_pixel,
    input  red,
    input  green,
    input  blue,
    output data_out,
    output pixel_done,
    output protocol_err
  );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// WS2812 bit encoder: serialises one 24-bit GRB pixel, MSB first, as BIT_CYCLES-long
// bit cells whose high phase is T0H or T1H cycles; flags controller protocol misuse.
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 15,
  parameter int T0H        = 5,
  parameter int T1H        = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ws2812_bit_encoder_if.slave  bus
);

  localparam logic [3:0] LAST_CYCLE = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] T0H_CYC    = 4'(T0H);
  localparam logic [3:0] T1H_CYC    = 4'(T1H);
  localparam logic [4:0] LAST_BIT   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] sreg_q, sreg_d;
  logic [3:0]  cycle_cnt_q, cycle_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        data_out_q, data_out_d;
  logic        pixel_done_q, pixel_done_d;
  logic        protocol_err_q, protocol_err_d;

  logic [3:0]  cycle_nxt_s;
  logic [3:0]  high_cyc_s;

  // High time of the bit currently at the head of the shift register.
  assign cycle_nxt_s = cycle_cnt_q + 4'd1;
  assign high_cyc_s  = sreg_q[23] ? T1H_CYC : T0H_CYC;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d        = state_q;
    sreg_d         = sreg_q;
    cycle_cnt_d    = cycle_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    data_out_d     = 1'b0;
    pixel_done_d   = 1'b0;
    protocol_err_d = protocol_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_sreg) begin
          sreg_d         = {bus.green, bus.red, bus.blue};
          state_d        = ST_LOADED;
          protocol_err_d = protocol_err_q | bus.transmit_pixel;
        end else if (bus.transmit_pixel) begin
          // Transmit without a captured pixel: refuse to drive the line.
          protocol_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOADED: begin
        if (bus.load_sreg) begin
          sreg_d         = {bus.green, bus.red, bus.blue};
          state_d        = ST_LOADED;
          protocol_err_d = protocol_err_q | bus.transmit_pixel;
        end else if (bus.transmit_pixel) begin
          state_d     = ST_SHIFT;
          cycle_cnt_d = 4'd0;
          bit_cnt_d   = 5'd0;
          data_out_d  = 1'b1;
        end else begin
          state_d = ST_LOADED;
        end
      end

      ST_SHIFT: begin
        // The final cell closes on the cycle after the transmit window, so
        // completion must win over the window-dropped check.
        if ((cycle_cnt_q == LAST_CYCLE) && (bit_cnt_q == LAST_BIT)) begin
          state_d        = ST_IDLE;
          cycle_cnt_d    = 4'd0;
          bit_cnt_d      = 5'd0;
          pixel_done_d   = 1'b1;
          protocol_err_d = protocol_err_q | bus.load_sreg;
        end else if (!bus.transmit_pixel) begin
          state_d        = ST_IDLE;
          cycle_cnt_d    = 4'd0;
          bit_cnt_d      = 5'd0;
          protocol_err_d = 1'b1;
        end else begin
          protocol_err_d = protocol_err_q | bus.load_sreg;
          if (cycle_cnt_q != LAST_CYCLE) begin
            cycle_cnt_d = cycle_nxt_s;
            data_out_d  = (cycle_nxt_s < high_cyc_s);
          end else begin
            sreg_d      = {sreg_q[22:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + 5'd1;
            cycle_cnt_d = 4'd0;
            data_out_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cycle_cnt_d = 4'd0;
        bit_cnt_d   = 5'd0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sreg_q         <= 24'd0;
      cycle_cnt_q    <= 4'd0;
      bit_cnt_q      <= 5'd0;
      data_out_q     <= 1'b0;
      pixel_done_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sreg_q         <= sreg_d;
      cycle_cnt_q    <= cycle_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      data_out_q     <= data_out_d;
      pixel_done_q   <= pixel_done_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.pixel_done   = pixel_done_q;
  assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Scoreboard bench for ws2812_bit_encoder: drivers queue the expected GRB word per pixel,
// a monitor decodes the serial line and checks it when pixel_done appears.
module tb_ws2812_bit_encoder;

  logic clk = 1'b0;
  logic rst_n;

  ws2812_bit_encoder_if bus ();

  ws2812_bit_encoder #(
    .BIT_CYCLES (15),
    .T0H        (5),
    .T1H        (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] word;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  logic exp_err;

  logic        mon_prev;
  logic        mon_open;
  int          mon_hi;
  int          mon_per;
  int          mon_nbits;
  int          mon_viol;
  logic [23:0] mon_word;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_clear();
    mon_open  = 1'b0;
    mon_hi    = 0;
    mon_per   = 0;
    mon_nbits = 0;
    mon_viol  = 0;
    mon_word  = 24'd0;
  endtask

  task automatic mon_close_bit();
    logic b;
    b = (mon_hi == 10);
    if ((mon_per != 15) || ((mon_hi != 5) && (mon_hi != 10))) mon_viol++;
    mon_word = {mon_word[22:0], b};
    mon_nbits++;
  endtask

  // Monitor: decode cells from data_out, compare on each pixel_done.
  initial begin
    mon_clear();
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_clear();
        mon_prev = 1'b0;
      end else begin
        if (bus.load_sreg && !bus.transmit_pixel) mon_clear();
        if (bus.pixel_done) begin
          if (mon_open) mon_close_bit();
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel_done: got pulse, expected none (t=%0t)", $time);
          end else begin
            mon_e = sb_q.pop_front();
            n_popped++;
            check("pixel_bits",   mon_nbits,        24);
            check("pixel_word",   mon_word,         mon_e.word);
            check("pixel_timing", mon_viol,         0);
            check("pixel_err",    bus.protocol_err, mon_e.err);
          end
          mon_clear();
        end else if (bus.data_out && !mon_prev) begin
          if (mon_open) mon_close_bit();
          mon_open = 1'b1;
          mon_hi   = 1;
          mon_per  = 1;
        end else if (mon_open) begin
          mon_per++;
          if (bus.data_out) mon_hi++;
        end
        mon_prev = bus.data_out;
      end
    end
  end

  task automatic run_pixel(input logic [23:0] grb, input int tx_cycles,
                           input bit overlap, input int mid_load_at);
    bit   completes = (tx_cycles >= 360);
    logic next_err;
    next_err = (overlap || (mid_load_at >= 0) || !completes) ? 1'b1 : exp_err;
    if (completes) begin
      sb_q.push_back({grb, next_err});
      n_pushed++;
    end
    @(posedge clk); #1;
    bus.load_sreg = 1'b1;
    {bus.green, bus.red, bus.blue} = grb;
    bus.transmit_pixel = overlap;
    @(posedge clk); #1;
    {bus.green, bus.red, bus.blue} = ~grb;
    bus.transmit_pixel = 1'b1;
    for (int c = 0; c < tx_cycles; c++) begin
      bus.load_sreg = (c == mid_load_at);
      @(posedge clk); #1;
    end
    bus.load_sreg      = 1'b0;
    bus.transmit_pixel = 1'b0;
    exp_err = next_err;
    @(posedge clk); #1;
    check("done_pulse",     bus.pixel_done,   completes);
    check("data_out_after", bus.data_out,     1'b0);
    check("err_after",      bus.protocol_err, exp_err);
    @(posedge clk); #1;
    check("done_single",    bus.pixel_done,   1'b0);
  endtask

  task automatic no_load_tx(input int n);
    bit hi_seen = 1'b0;
    @(posedge clk); #1;
    bus.transmit_pixel = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (bus.data_out) hi_seen = 1'b1;
    end
    @(posedge clk); #1;
    bus.transmit_pixel = 1'b0;
    exp_err = 1'b1;
    check("noload_data", hi_seen,          1'b0);
    check("noload_err",  bus.protocol_err, exp_err);
  endtask

  task automatic reset_mid_pixel();
    @(posedge clk); #1;
    bus.load_sreg = 1'b1;
    {bus.green, bus.red, bus.blue} = 24'h123456;
    @(posedge clk); #1;
    bus.load_sreg      = 1'b0;
    bus.transmit_pixel = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check("rst_async_data", bus.data_out,     1'b0);
    check("rst_async_done", bus.pixel_done,   1'b0);
    check("rst_async_err",  bus.protocol_err, exp_err);
    bus.transmit_pixel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_data", bus.data_out,     1'b0);
    check("post_rst_err",  bus.protocol_err, exp_err);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n              = 1'b0;
    bus.load_sreg      = 1'b0;
    bus.transmit_pixel = 1'b0;
    exp_err            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ii;
    rst_n              = 1'b1;
    bus.load_sreg      = 1'b0;
    bus.transmit_pixel = 1'b0;
    bus.red            = 8'h00;
    bus.green          = 8'h00;
    bus.blue           = 8'h00;
    exp_err            = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_data", bus.data_out,     1'b0);
    check("reset_done", bus.pixel_done,   1'b0);
    check("reset_err",  bus.protocol_err, exp_err);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_pixel(24'hFF0000, 360, 1'b0, -1);
    run_pixel(24'hA53C81, 360, 1'b0, -1);
    run_pixel(24'h000000, 360, 1'b0, -1);
    run_pixel(24'hFFFFFF, 360, 1'b0, -1);
    run_pixel(24'h800001, 360, 1'b0, -1);

    for (int i = 0; i < 64; i++) begin
      ii = 8'(i);
      run_pixel({ii, ~ii, ii ^ 8'h5A}, 360, 1'b0, -1);
    end

    no_load_tx(20);
    reset_mid_pixel();
    no_load_tx(20);

    apply_reset();
    run_pixel(24'h5AC3E7, 100, 1'b0, -1);
    run_pixel(24'h0F1E2D, 360, 1'b0, -1);

    apply_reset();
    run_pixel(24'hC0FFEE, 360, 1'b1, -1);

    apply_reset();
    run_pixel(24'h13579B, 360, 1'b0, 50);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty",   sb_q.size(), 0);
    check("done_count", n_popped,    n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
